check_collector: RTL

//  Scoreboard stage directly downstream of the check_level stage of the testbench sequencer wrapper.

---
 rtl/check_collector_pkg.sv | 27 ++
 rtl/check_collector_err_fifo.sv | 57 +++++
 rtl/check_collector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/check_collector_pkg.sv
// Shared types and helpers for the check_collector scoreboard stage.
package check_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } col_state_t;

    // Entry layout for the default configuration (5 aliases, 32-bit values)
    localparam int ERR_IDX_W  = 3;
    localparam int ERR_DATA_W = 32;

    typedef struct packed {
        logic [ERR_IDX_W-1:0]  idx;
        logic [ERR_DATA_W-1:0] exp;
        logic [ERR_DATA_W-1:0] obs;
    } err_entry_t;

    // Increment that holds at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/check_collector_err_fifo.sv
// Synchronous first-word fall-through FIFO holding failing-check records.
module err_fifo #(
    parameter int W     = 67,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    // A simultaneous pop frees the slot the push lands in
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/check_collector.sv
// Check-result scoreboard: counts passes/fails, logs fails, issues the verdict.
// Optional idle watchdog enabled by defining CHECK_COLLECT_TIMEOUT_EN.
module check_collector
    import check_collector_pkg::*;
#(
    parameter int CHECK_SIZE  = 5,
    parameter int CHECK_WIDTH = 32,
    parameter int ERR_DEPTH   = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 1000,
    localparam int IDX_W      = (CHECK_SIZE > 1) ? $clog2(CHECK_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_end_test,
    input  logic                   i_chk_valid,
    output logic                   o_chk_ready,
    input  logic [IDX_W-1:0]       i_chk_idx,
    input  logic [CHECK_WIDTH-1:0] i_chk_exp,
    input  logic [CHECK_WIDTH-1:0] i_chk_obs,
    output logic [CNT_WIDTH-1:0]   o_pass_cnt,
    output logic [CNT_WIDTH-1:0]   o_fail_cnt,
    output logic [CHECK_SIZE-1:0]  o_fail_map,
    input  logic                   i_err_rd,
    output logic                   o_err_valid,
    output logic [IDX_W-1:0]       o_err_idx,
    output logic [CHECK_WIDTH-1:0] o_err_exp,
    output logic [CHECK_WIDTH-1:0] o_err_obs,
    output logic                   o_err_ovf,
    output logic                   o_done,
    output logic                   o_pass,
    output logic                   o_timeout
);
    localparam int ENTRY_W = IDX_W + 2 * CHECK_WIDTH;

    col_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
    logic [CHECK_SIZE-1:0] fail_map_q, fail_map_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;

    logic                  xfer;
    logic                  fail_xfer;
    logic                  arm;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic [CHECK_SIZE-1:0] map_set;
    logic                  to_fire;
    logic                  timeout_cur;

    assign o_chk_ready = (state_q == ST_COLLECT);
    assign xfer        = i_chk_valid & o_chk_ready;
    assign fail_xfer   = xfer & (i_chk_exp != i_chk_obs);
    assign arm         = i_start & (state_q != ST_COLLECT);
    assign fifo_pop    = i_err_rd & ~fifo_empty;
    assign fifo_push   = fail_xfer;

    // Out-of-range indices match no bit here, so they leave the map untouched
    generate
        for (genvar gi = 0; gi < CHECK_SIZE; gi++) begin : g_map
            assign map_set[gi] = fail_xfer && (i_chk_idx == IDX_W'(gi));
        end
    endgenerate

`ifdef CHECK_COLLECT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        to_fire   = 1'b0;
        if (arm) begin
            idle_d    = '0;
            timeout_d = 1'b0;
        end else if (state_q == ST_COLLECT) begin
            if (xfer) begin
                idle_d = '0;
            end else if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
                to_fire   = 1'b1;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_cur = timeout_q;
    assign o_timeout   = timeout_q;
`else
    assign to_fire     = 1'b0;
    assign timeout_cur = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        fail_map_d = fail_map_q;
        ovf_d      = ovf_q;
        done_d     = done_q;
        pass_d     = pass_q;
        if (arm) begin
            state_d    = ST_COLLECT;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            fail_map_d = '0;
            ovf_d      = 1'b0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
        end else if (state_q == ST_COLLECT) begin
            if (xfer && !fail_xfer)
                pass_cnt_d = CNT_WIDTH'(sat_inc(32'(pass_cnt_q), CNT_WIDTH));
            if (fail_xfer)
                fail_cnt_d = CNT_WIDTH'(sat_inc(32'(fail_cnt_q), CNT_WIDTH));
            fail_map_d = fail_map_q | map_set;
            if (fail_xfer && fifo_full && !fifo_pop)
                ovf_d = 1'b1;
            // Verdict uses next-state values so a closing transfer is included
            if (i_end_test || to_fire) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = (fail_cnt_d == '0) && !ovf_d && !(timeout_cur || to_fire);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            fail_map_q <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            fail_map_q <= fail_map_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    err_fifo #(
        .W     (ENTRY_W),
        .DEPTH (ERR_DEPTH)
    ) u_err_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (arm),
        .push  (fifo_push),
        .din   ({i_chk_idx, i_chk_exp, i_chk_obs}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_err_valid = ~fifo_empty;
    assign o_err_idx   = fifo_dout[ENTRY_W-1 -: IDX_W];
    assign o_err_exp   = fifo_dout[2*CHECK_WIDTH-1 -: CHECK_WIDTH];
    assign o_err_obs   = fifo_dout[CHECK_WIDTH-1:0];
    assign o_pass_cnt  = pass_cnt_q;
    assign o_fail_cnt  = fail_cnt_q;
    assign o_fail_map  = fail_map_q;
    assign o_err_ovf   = ovf_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;

endmodule
